// File: rtl/aging_tb_arbiter_if.sv
// Aging-table arbiter bus: packet-path and inspector request/grant
// channels, shared read-data return and the table RAM strobes.
interface aging_tb_arbiter_if #(
    parameter int w_agingTb = 17,
    parameter int d_agingTb = 3
);
    // Packet path
    logic                 pkt_req;
    logic                 pkt_wr;
    logic [d_agingTb-1:0] pkt_idx;
    logic [w_agingTb-1:0] pkt_wdata;
    logic                 pkt_gnt;
    logic                 pkt_rdata_valid;

    // Inspector
    logic                 insp_req;
    logic                 insp_wr;
    logic [d_agingTb-1:0] insp_idx;
    logic [w_agingTb-1:0] insp_wdata;
    logic                 insp_gnt;
    logic                 insp_rdata_valid;
    logic                 insp_drop;

    // Shared read data
    logic [w_agingTb-1:0] rdata;

    // Table RAM
    logic [d_agingTb-1:0] ram_idx;
    logic                 ram_rdValid;
    logic                 ram_wrValid;
    logic [w_agingTb-1:0] ram_data;
    logic [w_agingTb-1:0] ram_ctx;

    // Arbiter side
    modport slave (
        input  pkt_req, pkt_wr, pkt_idx, pkt_wdata,
        input  insp_req, insp_wr, insp_idx, insp_wdata,
        input  ram_ctx,
        output pkt_gnt, pkt_rdata_valid,
        output insp_gnt, insp_rdata_valid, insp_drop,
        output rdata,
        output ram_idx, ram_rdValid, ram_wrValid, ram_data
    );

    // Requester / RAM environment side
    modport master (
        output pkt_req, pkt_wr, pkt_idx, pkt_wdata,
        output insp_req, insp_wr, insp_idx, insp_wdata,
        output ram_ctx,
        input  pkt_gnt, pkt_rdata_valid,
        input  insp_gnt, insp_rdata_valid, insp_drop,
        input  rdata,
        input  ram_idx, ram_rdValid, ram_wrValid, ram_data
    );
endinterface

// File: rtl/aging_tb_arbiter.sv
// Aging-table access arbiter. Two requesters (packet path, inspector)
// share one table port. The packet path normally wins; the inspector is
// guaranteed a slot after MAX_PKT_BURST consecutive packet grants.
// Reads take a fixed four-cycle round trip through the table; an
// inspector read-modify-write is dropped if the packet path wrote the
// same entry in between.
module aging_tb_arbiter #(
    parameter int w_agingTb     = 17,
    parameter int d_agingTb     = 3,
    parameter int MAX_PKT_BURST = 4
) (
    input  logic clk,
    input  logic reset,
    aging_tb_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_W1   = 2'd1;
    localparam logic [1:0] S_RD_W2   = 2'd2;
    localparam logic [1:0] S_RD_DONE = 2'd3;

    localparam logic [3:0] MAX_CNT = 4'(MAX_PKT_BURST);

    // Saturating increment for the starvation counter
    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
        if (v >= lim) begin
            return lim;
        end
        return v + 4'd1;
    endfunction

    // Control state
    logic [1:0]           r_state;
    logic [3:0]           r_starve_cnt;
    logic                 r_pend_valid;
    logic [d_agingTb-1:0] r_pend_idx;
    logic                 r_dirty;
    logic                 r_rd_owner_insp;

    // Registered outputs
    logic                 r_pkt_gnt;
    logic                 r_insp_gnt;
    logic                 r_pkt_rdata_valid;
    logic                 r_insp_rdata_valid;
    logic                 r_insp_drop;
    logic [w_agingTb-1:0] r_rdata;
    logic [d_agingTb-1:0] r_ram_idx;
    logic                 r_ram_rdValid;
    logic                 r_ram_wrValid;
    logic [w_agingTb-1:0] r_ram_data;

    // Arbitration decision
    logic                 w_arb_en;
    logic                 w_insp_pri;
    logic                 w_insp_win;
    logic                 w_pkt_win;
    logic                 w_any_win;
    logic                 w_win_wr;
    logic [d_agingTb-1:0] w_win_idx;
    logic [w_agingTb-1:0] w_win_wdata;
    logic                 w_drop;
    logic                 w_pkt_hits_pend;

    // Arbitrate only in IDLE and never in a grant cycle, which leaves a
    // one-cycle bubble after every grant.
    assign w_arb_en   = (r_state == S_IDLE) && !r_pkt_gnt && !r_insp_gnt;
    assign w_insp_pri = bus.insp_req && (r_starve_cnt == MAX_CNT);
    assign w_insp_win = w_arb_en && bus.insp_req && (w_insp_pri || !bus.pkt_req);
    assign w_pkt_win  = w_arb_en && bus.pkt_req && !w_insp_pri;
    assign w_any_win  = w_insp_win || w_pkt_win;

    assign w_win_wr    = w_insp_win ? bus.insp_wr    : bus.pkt_wr;
    assign w_win_idx   = w_insp_win ? bus.insp_idx   : bus.pkt_idx;
    assign w_win_wdata = w_insp_win ? bus.insp_wdata : bus.pkt_wdata;

    // An inspector write is stale if the packet path overwrote the entry
    // the inspector last read.
    assign w_drop = w_insp_win && bus.insp_wr && r_pend_valid && r_dirty &&
                    (bus.insp_idx == r_pend_idx);

    assign w_pkt_hits_pend = r_pend_valid && (bus.pkt_idx == r_pend_idx);

    // FSM, grant pulses, RAM strobes and read-data return
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= S_IDLE;
            r_rd_owner_insp    <= 1'b0;
            r_pkt_gnt          <= 1'b0;
            r_insp_gnt         <= 1'b0;
            r_pkt_rdata_valid  <= 1'b0;
            r_insp_rdata_valid <= 1'b0;
            r_insp_drop        <= 1'b0;
            r_rdata            <= '0;
            r_ram_idx          <= '0;
            r_ram_rdValid      <= 1'b0;
            r_ram_wrValid      <= 1'b0;
            r_ram_data         <= '0;
        end else begin
            r_pkt_gnt          <= w_pkt_win;
            r_insp_gnt         <= w_insp_win;
            r_insp_drop        <= w_drop;
            r_ram_rdValid      <= w_any_win && !w_win_wr;
            r_ram_wrValid      <= w_any_win && w_win_wr && !w_drop;
            r_pkt_rdata_valid  <= 1'b0;
            r_insp_rdata_valid <= 1'b0;

            if (w_any_win) begin
                r_ram_idx <= w_win_idx;
            end
            if (w_any_win && w_win_wr && !w_drop) begin
                r_ram_data <= w_win_wdata;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_any_win && !w_win_wr) begin
                        r_state         <= S_RD_W1;
                        r_rd_owner_insp <= w_insp_win;
                    end
                end
                S_RD_W1: begin
                    r_state <= S_RD_W2;
                end
                S_RD_W2: begin
                    r_state <= S_RD_DONE;
                end
                S_RD_DONE: begin
                    r_rdata            <= bus.ram_ctx;
                    r_pkt_rdata_valid  <= !r_rd_owner_insp;
                    r_insp_rdata_valid <= r_rd_owner_insp;
                    r_state            <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Starvation counter: counts packet grants the inspector sat through
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= 4'd0;
        end else if (w_insp_win || !bus.insp_req) begin
            r_starve_cnt <= 4'd0;
        end else if (w_pkt_win) begin
            r_starve_cnt <= sat_inc(r_starve_cnt, MAX_CNT);
        end
    end

    // Hazard tracking between an inspector read and its follow-up write
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_valid <= 1'b0;
            r_pend_idx   <= '0;
            r_dirty      <= 1'b0;
        end else if (w_insp_win && !bus.insp_wr) begin
            r_pend_valid <= 1'b1;
            r_pend_idx   <= bus.insp_idx;
            r_dirty      <= 1'b0;
        end else if (w_insp_win && bus.insp_wr) begin
            r_pend_valid <= 1'b0;
            r_dirty      <= 1'b0;
        end else if (w_pkt_win && bus.pkt_wr && w_pkt_hits_pend) begin
            r_dirty <= 1'b1;
        end
    end

    assign bus.pkt_gnt          = r_pkt_gnt;
    assign bus.insp_gnt         = r_insp_gnt;
    assign bus.pkt_rdata_valid  = r_pkt_rdata_valid;
    assign bus.insp_rdata_valid = r_insp_rdata_valid;
    assign bus.insp_drop        = r_insp_drop;
    assign bus.rdata            = r_rdata;
    assign bus.ram_idx          = r_ram_idx;
    assign bus.ram_rdValid      = r_ram_rdValid;
    assign bus.ram_wrValid      = r_ram_wrValid;
    assign bus.ram_data         = r_ram_data;

endmodule
